// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among N_REQ issue sources.
// Two-stage pipe: issue register drives the ALU, result register tags the winning source.
module alu_issue_arbiter #(
    parameter int N_REQ    = 4,
    parameter int SRC_W    = $clog2(N_REQ),
    parameter int INSTR_W  = 88,
    parameter int RESULT_W = 38
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [N_REQ-1:0]                req_valid,
    input  logic [N_REQ-1:0][INSTR_W-1:0]   req_data,
    output logic [N_REQ-1:0]                req_ready,
    output logic                            alu_valid,
    output logic [INSTR_W-1:0]              alu_data,
    input  logic                            alu_ready,
    input  logic [RESULT_W-1:0]             alu_result,
    output logic                            res_valid,
    output logic [RESULT_W-1:0]             res_data,
    output logic [SRC_W-1:0]                res_src,
    input  logic                            res_ready
);

    localparam logic [SRC_W:0]   N_REQ_W  = (SRC_W+1)'(N_REQ);
    localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N_REQ - 1);

    logic                r_iss_v;
    logic [INSTR_W-1:0]  r_iss_data;
    logic [SRC_W-1:0]    r_iss_src;
    logic                r_res_v;
    logic [RESULT_W-1:0] r_res_data;
    logic [SRC_W-1:0]    r_res_src;
    logic [SRC_W-1:0]    r_rr_ptr;

    logic                w_res_free;
    logic                w_iss_adv;
    logic                w_iss_free;
    logic                w_found;
    logic [SRC_W-1:0]    w_grant_idx;
    logic                w_grant_en;
    logic [SRC_W-1:0]    w_rr_next;

    assign w_res_free = !r_res_v || res_ready;
    assign w_iss_adv  = r_iss_v && alu_ready && w_res_free;
    assign w_iss_free = !r_iss_v || w_iss_adv;

    // Scan requesters starting at the round-robin pointer; only req_valid feeds the grant.
    always_comb begin
        logic [SRC_W:0] idx;
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, r_rr_ptr} + (SRC_W+1)'(k);
            if (idx >= N_REQ_W) begin
                idx = idx - N_REQ_W;
            end
            if (!w_found && req_valid[idx[SRC_W-1:0]]) begin
                w_found     = 1'b1;
                w_grant_idx = idx[SRC_W-1:0];
            end
        end
    end

    assign w_grant_en = w_found && w_iss_free && !flush && !rst;
    assign w_rr_next  = (w_grant_idx == LAST_IDX) ? '0 : w_grant_idx + 1'b1;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = w_grant_en && (w_grant_idx == SRC_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iss_v   <= 1'b0;
            r_res_v   <= 1'b0;
            r_rr_ptr  <= '0;
            r_iss_src <= '0;
            r_res_src <= '0;
        end else if (flush) begin
            r_iss_v <= 1'b0;
            r_res_v <= 1'b0;
        end else begin
            if (w_iss_adv) begin
                r_res_src <= r_iss_src;
                r_res_v   <= 1'b1;
            end else if (res_ready) begin
                r_res_v <= 1'b0;
            end
            if (w_grant_en) begin
                r_iss_src <= w_grant_idx;
                r_iss_v   <= 1'b1;
                r_rr_ptr  <= w_rr_next;
            end else if (w_iss_adv) begin
                r_iss_v <= 1'b0;
            end
        end
    end

    // Payload registers carry no reset; their contents only matter while the matching valid is set.
    always_ff @(posedge clk) begin
        if (w_grant_en) begin
            r_iss_data <= req_data[w_grant_idx];
        end
        if (w_iss_adv) begin
            r_res_data <= alu_result;
        end
    end

    assign alu_valid = r_iss_v;
    assign alu_data  = r_iss_data;
    assign res_valid = r_res_v;
    assign res_data  = r_res_data;
    assign res_src   = r_res_src;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Randomised bench for alu_issue_arbiter: behavioural pipeline model, in-order scoreboard,
// and a few directed scenarios with literal expectations.
module tb_alu_issue_arbiter;

    localparam int N = 4;
    localparam int IW = 88;
    localparam int RW = 38;

    logic                  clk = 1'b0;
    logic                  rst, flush, alu_ready, res_ready;
    logic [N-1:0]          req_valid;
    logic [N-1:0][IW-1:0]  req_data;
    logic [N-1:0]          req_ready;
    logic                  alu_valid, res_valid;
    logic [IW-1:0]         alu_data;
    logic [RW-1:0]         alu_result, res_data;
    logic [1:0]            res_src;

    int n_vec = 0;
    int n_err = 0;

    // Model state: what each pipeline slot must hold, plus the fairness pointer.
    logic          m_iss_v, m_res_v;
    logic [IW-1:0] m_iss_instr;
    int            m_iss_src, m_res_src, m_rr;
    logic [RW-1:0] m_res_data;

    typedef struct { int src; logic [IW-1:0] instr; } op_t;
    op_t sb_q[$];

    alu_issue_arbiter #(.N_REQ(N), .SRC_W(2), .INSTR_W(IW), .RESULT_W(RW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .alu_valid(alu_valid), .alu_data(alu_data), .alu_ready(alu_ready),
        .alu_result(alu_result),
        .res_valid(res_valid), .res_data(res_data), .res_src(res_src),
        .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    // Instr: op[87:84] funct3[83:81] imm[80:69] rd[68:64] rs1[63:32] rs2[31:0]
    // Result: ex_valid[37] rd[36:32] rd_val[31:0]
    function automatic logic [RW-1:0] alu_fn(input logic [IW-1:0] ins);
        logic [31:0] a, b, v;
        logic        ex;
        a = ins[63:32];
        b = ins[31:0];
        ex = 1'b0;
        case (ins[87:84])
            4'd0: v = a + b;
            4'd1: v = a - b;
            4'd2: v = a ^ b;
            4'd3: v = a & b;
            default: begin v = 32'd0; ex = 1'b1; end
        endcase
        return {ex, ins[68:64], v};
    endfunction

    assign alu_result = alu_fn(alu_data);

    function automatic logic [IW-1:0] mk_instr(input logic [3:0] op, input logic [4:0] rd,
                                               input logic [31:0] a, input logic [31:0] b);
        return {op, 3'd0, 12'd0, rd, a, b};
    endfunction

    function automatic logic [IW-1:0] rand_instr();
        logic [3:0] op;
        op = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
        return mk_instr(op, 5'($urandom), $urandom, $urandom);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_iss_v = 1'b0;
        m_res_v = 1'b0;
        m_res_src = 0;
        m_rr = 0;
        sb_q.delete();
    endtask

    // One clock cycle: drive inputs, check every output against the model, then advance the model.
    task automatic step(input logic r, input logic f, input logic [N-1:0] rv,
                        input logic ar, input logic rr_in,
                        input logic [IW-1:0] fixed_instr = '0, input bit use_fixed = 0);
        logic [N-1:0] exp_ready;
        logic         free, adv;
        int           g;
        @(negedge clk);
        rst = r; flush = f; req_valid = rv; alu_ready = ar; res_ready = rr_in;
        for (int i = 0; i < N; i++) req_data[i] = use_fixed ? fixed_instr : rand_instr();
        #1;
        free = !m_iss_v || (ar && (!m_res_v || rr_in));
        exp_ready = '0;
        g = -1;
        if (free && !f && !r) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && rv[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", req_ready, exp_ready);
        chk("alu_valid", alu_valid, m_iss_v);
        if (m_iss_v) chk("alu_data", alu_data, m_iss_instr);
        chk("res_valid", res_valid, m_res_v);
        if (m_res_v) begin
            chk("res_data", res_data, m_res_data);
            chk("res_src", res_src, m_res_src);
        end
        if (!r && m_res_v && rr_in) begin
            if (sb_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL sb_extra: got result src %0d expected none", res_src);
            end else begin
                op_t e;
                e = sb_q.pop_front();
                chk("sb_src", res_src, e.src);
                chk("sb_data", res_data, alu_fn(e.instr));
                $display("result src=%0d data=%0h", res_src, res_data);
            end
        end
        if (r) begin
            model_reset();
        end else if (f) begin
            m_iss_v = 1'b0;
            m_res_v = 1'b0;
            sb_q.delete();
        end else begin
            adv = m_iss_v && ar && (!m_res_v || rr_in);
            if (adv) begin
                m_res_data = alu_fn(m_iss_instr);
                m_res_src  = m_iss_src;
                m_res_v    = 1'b1;
            end else if (rr_in) begin
                m_res_v = 1'b0;
            end
            if (g >= 0) begin
                op_t o;
                m_iss_instr = req_data[g];
                m_iss_src   = g;
                m_iss_v     = 1'b1;
                m_rr        = (g + 1) % N;
                o.src = g;
                o.instr = req_data[g];
                sb_q.push_back(o);
            end else if (adv) begin
                m_iss_v = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = '0; alu_ready = 1'b1; res_ready = 1'b1;
        req_data = '0;
        model_reset();

        // Reset: no grant while held, all valids low afterwards
        step(1, 0, 4'b1111, 1, 1);
        step(1, 0, 4'b1111, 1, 1);
        chk("lit_rst_ready", req_ready, 4'b0000);
        step(0, 0, 4'b0000, 1, 1);
        chk("lit_rst_alu_valid", alu_valid, 1'b0);
        chk("lit_rst_res_valid", res_valid, 1'b0);
        chk("lit_rst_res_src", res_src, 2'd0);

        // Single ADD 5+7 from requester 0
        step(0, 0, 4'b0001, 1, 1, mk_instr(4'd0, 5'd3, 32'd5, 32'd7), 1);
        chk("lit_add_grant", req_ready, 4'b0001);
        step(0, 0, 4'b0000, 1, 1);
        chk("lit_add_alu_valid", alu_valid, 1'b1);
        step(0, 0, 4'b0000, 1, 1);
        chk("lit_add_res_valid", res_valid, 1'b1);
        chk("lit_add_rd_val", res_data[31:0], 32'd12);
        chk("lit_add_res_src", res_src, 2'd0);

        // Wrap: pointer moves to 3 after granting 2, then 3 -> 0
        step(0, 0, 4'b0100, 1, 1);
        chk("lit_grant2", req_ready, 4'b0100);
        step(0, 0, 4'b1001, 1, 1);
        chk("lit_wrap3", req_ready, 4'b1000);
        step(0, 0, 4'b1001, 1, 1);
        chk("lit_wrap0", req_ready, 4'b0001);

        // All four streaming: strict rotation
        for (int c = 0; c < 8; c++) begin
            step(0, 0, 4'b1111, 1, 1);
            chk("lit_rotate", req_ready, 4'b0001 << ((c + 1) % 4));
        end

        // Backpressure: stall writeback for 5 cycles, then drain
        for (int c = 0; c < 5; c++) step(0, 0, 4'b1111, 1, 0);
        chk("lit_bp_ready", req_ready, 4'b0000);
        for (int c = 0; c < 3; c++) step(0, 0, 4'b0000, 1, 1);

        // Flush with both stages full
        step(0, 0, 4'b1111, 1, 1);
        step(0, 0, 4'b1111, 1, 1);
        step(0, 1, 4'b1111, 1, 1);
        chk("lit_flush_ready", req_ready, 4'b0000);
        step(0, 0, 4'b0000, 1, 1);
        chk("lit_flush_alu_valid", alu_valid, 1'b0);
        chk("lit_flush_res_valid", res_valid, 1'b0);
        step(0, 0, 4'b1111, 1, 1);

        // Reset mid-stream, then lowest valid index wins
        step(0, 0, 4'b1111, 1, 1);
        step(1, 0, 4'b1111, 1, 1);
        step(0, 0, 4'b0110, 1, 1);
        chk("lit_post_rst_grant", req_ready, 4'b0010);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0, 4'($urandom),
                 $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 75);
        end
        // Drain
        for (int c = 0; c < 4; c++) step(0, 0, 4'b0000, 1, 1);
        chk("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
